// File: rtl/mod_prod.sv
// Modular product (a * b) mod n by bit-serial add-and-double, one bit of a per clock.
// Used ahead of the Montgomery multiplier to scale operands by 2^WIDTH mod n.
module mod_prod #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             finished_next;
  logic             busy_next;

  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] t;
  logic [CNT_W-1:0] count;

  logic [WIDTH+1:0] m_sum;
  logic [WIDTH-1:0] m_next;
  logic [WIDTH:0]   t_dbl;
  logic [WIDTH-1:0] t_next;

  // One iteration; m < n and t < n keep every reduction to a single subtract
  always_comb begin
    m_sum = {2'b00, m};
    if (a_r[count]) begin
      m_sum = m_sum + {2'b00, t};
    end
    if (m_sum >= {2'b00, n_r}) begin
      m_next = WIDTH'(m_sum - {2'b00, n_r});
    end else begin
      m_next = WIDTH'(m_sum);
    end
    t_dbl = {t, 1'b0};
    if (t_dbl >= {1'b0, n_r}) begin
      t_next = WIDTH'(t_dbl - {1'b0, n_r});
    end else begin
      t_next = WIDTH'(t_dbl);
    end
  end

  // Next state and next registered flags
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_start) state_next = S_RUN;
      S_RUN:  if (count == LAST) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    finished_next = (state_next == S_DONE);
    busy_next     = (state_next != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch, iteration registers and outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_r        <= '0;
      n_r        <= '0;
      m          <= '0;
      t          <= '0;
      count      <= '0;
      o_result   <= '0;
      o_finished <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      if (state == S_IDLE && i_start) begin
        a_r   <= i_a;
        n_r   <= i_n;
        t     <= i_b;
        m     <= '0;
        count <= '0;
      end else if (state == S_RUN) begin
        m     <= m_next;
        t     <= t_next;
        count <= count + CNT_W'(1);
      end
      if (state == S_RUN && count == LAST) begin
        o_result <= m_next;
      end
      o_finished <= finished_next;
      o_busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_mod_prod.sv
// Scoreboarded bench for mod_prod: expected (a*b) mod n and its finish cycle are
// queued at start and matched against o_finished/o_result every cycle.
module tb_mod_prod;

  localparam int unsigned WIDTH = 256;

  logic             i_clk;
  logic             i_rst;
  logic             i_start;
  logic [WIDTH:0]   i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_result;
  logic             o_finished;
  logic             o_busy;

  mod_prod #(.WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_n        (i_n),
    .o_result   (o_result),
    .o_finished (o_finished),
    .o_busy     (o_busy)
  );

  typedef struct {
    int unsigned      fin_cyc;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic        mon_en;
  logic        mon_exp_fin;

  logic [WIDTH:0]   a_pow;
  logic [WIDTH:0]   a_ones;
  logic [WIDTH-1:0] n_big;
  logic [WIDTH-1:0] n_half;
  int unsigned      s;
  int unsigned      s2;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: full-width product then remainder
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH:0] a, input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] n);
    logic [2*WIDTH+1:0] p;
    p = {{(WIDTH+1){1'b0}}, a} * {{(WIDTH+2){1'b0}}, b};
    return WIDTH'(p % {{(WIDTH+2){1'b0}}, n});
  endfunction

  // Called at a negedge; returns at the next negedge with cyc == s (cycle 1 of the run)
  task automatic start_op(input logic [WIDTH:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] n, output int unsigned s_out);
    exp_t e;
    i_a     = a;
    i_b     = b;
    i_n     = n;
    i_start = 1'b1;
    s_out     = cyc + 1;
    e.fin_cyc = s_out + 257;
    e.res     = model(a, b, n);
    sb.push_back(e);
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge i_clk);
  endtask

  task automatic run_op(input logic [WIDTH:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] n);
    int unsigned st;
    start_op(a, b, n, st);
    wait_cyc(st + 258);
  endtask

  // Cycle-exact completion monitor
  always @(negedge i_clk) begin
    if (mon_en) begin
      mon_exp_fin = (sb.size() > 0) && (sb[0].fin_cyc == cyc);
      check("finished", WIDTH'(o_finished), WIDTH'(mon_exp_fin));
      if (mon_exp_fin) begin
        check("result", o_result, sb[0].res);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_n     = '0;
    mon_en  = 1'b0;
    a_pow   = '0;
    a_pow[WIDTH] = 1'b1;
    a_ones  = '0;
    a_ones[WIDTH-1:0] = '1;
    n_big   = '1;
    n_big   = n_big - WIDTH'(188);
    n_half  = '0;
    n_half[WIDTH-1] = 1'b1;
    n_half[0] = 1'b1;

    repeat (3) @(negedge i_clk);
    check("rst_busy", WIDTH'(o_busy), '0);
    check("rst_finished", WIDTH'(o_finished), '0);
    check("rst_result", o_result, '0);
    i_rst  = 1'b0;
    mon_en = 1'b1;
    @(negedge i_clk);

    // Small values with busy window trace
    start_op(257'd5, 256'd7, 256'd11, s);
    while (cyc <= s + 259) begin
      check("busy", WIDTH'(o_busy), WIDTH'((cyc >= s) && (cyc <= s + 257)));
      @(negedge i_clk);
    end
    check("result_hold", o_result, WIDTH'(2));

    // Montgomery pre-scale, small and full-width moduli
    run_op(a_pow, 256'd1, 256'd13);
    run_op(a_pow, 256'd5, 256'd13);
    run_op(a_pow, 256'd1, n_big);
    run_op(a_pow, 256'd3, n_big);

    // Zero operands
    run_op(257'd0, 256'd12345, n_half);
    run_op(a_ones, 256'd0, n_half);

    // Starts while busy are ignored; first start after DONE is taken
    start_op(257'd5, 256'd7, 256'd11, s);
    wait_cyc(s + 49);
    i_a = 257'd1;
    i_b = 256'd1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_cyc(s + 257);
    i_start = 1'b1;
    @(negedge i_clk);
    start_op(257'd1, 256'd1, 256'd11, s2);
    check("restart_cycle", WIDTH'(s2), WIDTH'(s + 259));
    wait_cyc(s2 + 258);

    // Reset mid-run discards the operation; a start alongside reset is ignored
    start_op(257'd5, 256'd7, 256'd11, s);
    wait_cyc(s + 99);
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_a     = 257'd1;
    i_b     = 256'd1;
    sb.delete();
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_start = 1'b0;
    check("midrst_busy", WIDTH'(o_busy), '0);
    check("midrst_finished", WIDTH'(o_finished), '0);
    check("midrst_result", o_result, '0);
    @(negedge i_clk);
    check("rst_start_ignored", WIDTH'(o_busy), '0);
    wait_cyc(s + 270);
    run_op(257'd5, 256'd7, 256'd11);

    check("sb_drained", WIDTH'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
